sram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives a 1-write/1-read OpenRAM macro (default 40 words x 72 bits) as its storage array.
- Upstream: a valid/ready producer. Downstream: a valid/ready consumer.
- The block turns the macro's registered-input, one-cycle read latency into a full-throughput stream.
- A 2-entry output buffer absorbs the read latency and consumer backpressure.

---
 rtl/sram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller around a 1W/1R SRAM macro with a 2-entry output buffer
module sram_fifo_ctrl #(
  parameter int DEPTH = 40,
  parameter int WIDTH = 72,
  parameter int AW    = 6,
  parameter int LW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             sram_csb0,
  output logic [AW-1:0]    sram_addr0,
  output logic [WIDTH-1:0] sram_din0,
  output logic             sram_csb1,
  output logic [AW-1:0]    sram_addr1,
  input  logic [WIDTH-1:0] sram_dout1
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [LW-1:0] DEPTH_CNT = LW'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_wcnt;
  logic [LW-1:0]    r_alloc;
  logic             r_inflt;
  logic [1:0]       r_ocnt;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic w_rd_issue;

  assign w_in_ready  = !rst && (r_alloc < DEPTH_CNT);
  assign w_out_valid = (r_ocnt != 2'd0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  // Only issue a read if the buffer will have room for it once it returns.
  assign w_rd_issue  = !rst && (r_wcnt != '0) &&
                       (({1'b0, r_ocnt} + {2'b00, r_inflt}) < (3'd2 + {2'b00, w_pop}));

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = r_buf0;
  assign level      = r_level;

  assign sram_csb0  = !w_push;
  assign sram_addr0 = r_wr_ptr;
  assign sram_din0  = in_data;
  assign sram_csb1  = !w_rd_issue;
  assign sram_addr1 = r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wcnt   <= '0;
      r_alloc  <= '0;
      r_inflt  <= 1'b0;
      r_ocnt   <= 2'd0;
      r_level  <= '0;
      r_buf0   <= '0;
      r_buf1   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_issue) begin
        r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
      end
      r_wcnt  <= r_wcnt + LW'(w_push) - LW'(w_rd_issue);
      r_alloc <= r_alloc + LW'(w_push) - LW'(r_inflt);
      r_inflt <= w_rd_issue;
      r_ocnt  <= r_ocnt + {1'b0, r_inflt} - {1'b0, w_pop};
      r_level <= r_level + LW'(w_push) - LW'(w_pop);

      // Returning read data lands at the buffer tail; a pop shifts the tail to the head.
      if (r_inflt && w_pop) begin
        if (r_ocnt == 2'd2) begin
          r_buf0 <= r_buf1;
          r_buf1 <= sram_dout1;
        end else begin
          r_buf0 <= sram_dout1;
        end
      end else if (r_inflt) begin
        if (r_ocnt == 2'd0) begin
          r_buf0 <= sram_dout1;
        end else begin
          r_buf1 <= sram_dout1;
        end
      end else if (w_pop) begin
        r_buf0 <= r_buf1;
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - self-checking bench for sram_fifo_ctrl with a behavioural SRAM and queue model
module tb_sram_fifo_ctrl;

  localparam int DEPTH = 40;
  localparam int WIDTH = 72;
  localparam int AW    = 6;
  localparam int LW    = 6;
  localparam logic [WIDTH-1:0] PAT_A5 = {9{8'hA5}};

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             sram_csb0;
  logic [AW-1:0]    sram_addr0;
  logic [WIDTH-1:0] sram_din0;
  logic             sram_csb1;
  logic [AW-1:0]    sram_addr1;
  logic [WIDTH-1:0] sram_dout1;

  sram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Macro model: inputs registered at the edge, read data valid the cycle after.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [WIDTH-1:0] model_q[$];
  int               pop_cyc_q[$];
  int               exp_waddr = 0;
  int               exp_raddr = 0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;

  always @(negedge clk) begin
    #4;
    if (rst) begin
      model_q.delete();
      exp_waddr  = 0;
      exp_raddr  = 0;
      stall_prev = 1'b0;
    end else begin
      chk("mon level", 72'(level), 72'(model_q.size()));
      if (out_valid) chk("mon valid_nonempty", 72'(model_q.size() != 0), 72'(1));
      if (!sram_csb0 && !sram_csb1) chk("mon addr_collision", 72'(sram_addr0 != sram_addr1), 72'(1));
      if (stall_prev) begin
        chk("mon stall_valid", 72'(out_valid), 72'(1));
        chk("mon stall_data", out_data, stall_data);
      end
      if (in_valid && in_ready) begin
        chk("mon wr_csb", 72'(sram_csb0), 72'(0));
        chk("mon wr_addr", 72'(sram_addr0), 72'(exp_waddr));
        chk("mon wr_data", sram_din0, in_data);
        model_q.push_back(in_data);
        exp_waddr = (exp_waddr + 1) % DEPTH;
      end
      if (!sram_csb1) begin
        chk("mon rd_addr", 72'(sram_addr1), 72'(exp_raddr));
        exp_raddr = (exp_raddr + 1) % DEPTH;
      end
      if (out_valid && out_ready) begin
        if (model_q.size() == 0) begin
          chk("mon pop_empty", 72'(1), 72'(0));
        end else begin
          chk("mon pop_data", out_data, model_q.pop_front());
        end
        pop_cyc_q.push_back(cyc);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             e_ov;
    logic [LW-1:0]    e_lvl;
    logic             e_ir;
    logic             e_csb0;
    logic             e_csb1;
    logic             chk_od;
    logic [WIDTH-1:0] e_od;
  } vec_t;

  vec_t vecs [11];

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((model_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s drained", name), 72'(n < 300), 72'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int p0;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, '0,     1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, '0};
    vecs[1]  = '{1'b1, 1'b1, '0,     1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, '0};
    for (int i = 2; i < 7; i++)
      vecs[i] = '{1'b0, 1'b0, '0,    1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1, '0};
    vecs[7]  = '{1'b0, 1'b1, PAT_A5, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1, '0};
    vecs[8]  = '{1'b0, 1'b0, '0,     1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 1'b1, 1'b1, '0};
    vecs[9]  = '{1'b0, 1'b0, '0,     1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b1, 1'b1, PAT_A5};
    vecs[10] = '{1'b0, 1'b0, '0,     1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, '0};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 72'(out_valid), 72'(vecs[i].e_ov));
      chk($sformatf("vec%0d level", i), 72'(level), 72'(vecs[i].e_lvl));
      chk($sformatf("vec%0d in_ready", i), 72'(in_ready), 72'(vecs[i].e_ir));
      chk($sformatf("vec%0d csb0", i), 72'(sram_csb0), 72'(vecs[i].e_csb0));
      chk($sformatf("vec%0d csb1", i), 72'(sram_csb1), 72'(vecs[i].e_csb1));
      if (vecs[i].chk_od) chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
    end

    // Back-to-back streaming through both pointer wraps.
    @(negedge clk);
    in_valid = 1'b0;
    pop_cyc_q.delete();
    out_ready = 1'b1;
    p0 = cyc;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 72'(i);
      chk("thru in_ready", 72'(in_ready), 72'(1));
      @(negedge clk);
    end
    drain("thru");
    chk("thru pop_count", 72'(pop_cyc_q.size()), 72'(100));
    if (pop_cyc_q.size() == 100) begin
      chk("thru first_latency", 72'(pop_cyc_q[0] - p0), 72'(3));
      chk("thru one_per_cycle", 72'(pop_cyc_q[99] - pop_cyc_q[0]), 72'(99));
    end

    // Fill to capacity with the consumer stalled.
    reset_dut();
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 72'(acc);
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("full accepted", 72'(acc), 72'(42));
    chk("full in_ready", 72'(in_ready), 72'(0));
    chk("full level", 72'(level), 72'(42));
    chk("full head_valid", 72'(out_valid), 72'(1));
    chk("full head_data", out_data, 72'(0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("full in_ready+1", 72'(in_ready), 72'(0));
    chk("full level+1", 72'(level), 72'(41));
    @(negedge clk);
    chk("full in_ready+2", 72'(in_ready), 72'(1));
    drain("full");

    // Random traffic against the queue model.
    reset_dut();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 72'({$urandom, $urandom, $urandom});
      out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    drain("random");

    // Reset while a read is in flight.
    reset_dut();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 72'(100 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("rstmid read_issued", 72'(sram_csb1), 72'(0));
    @(negedge clk);
    out_ready = 1'b0;
    chk("rstmid level_before", 72'(level), 72'(20));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid level", 72'(level), 72'(0));
    chk("rstmid out_valid", 72'(out_valid), 72'(0));
    chk("rstmid out_data", out_data, 72'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid discard_valid", 72'(out_valid), 72'(0));
    chk("rstmid discard_level", 72'(level), 72'(0));
    in_valid = 1'b1;
    in_data  = 72'h7;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid out_valid_rises", 72'(out_valid), 72'(1));
    chk("rstmid first_word", out_data, 72'h7);
    drain("rstmid");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
